// File: rtl/agilex_alm_lut_cfg_if.sv
// agilex_alm_lut_cfg_if
//   Byte-stream channel that carries configuration frames into
//   agilex_alm_lut_cfg.
//
//   in_valid   producer -> loader   byte is offered
//   in_ready   loader -> producer   byte may transfer this cycle
//   in_data    producer -> loader   configuration byte
//   in_parity  producer -> loader   odd-parity bit (only with ALM_CFG_PARITY_EN)
//
//   Build option: ALM_CFG_PARITY_EN adds in_parity to the channel.

interface agilex_alm_lut_cfg_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
`ifdef ALM_CFG_PARITY_EN
  logic       in_parity;

  modport master (output in_valid, output in_data, output in_parity, input in_ready);
  modport slave  (input in_valid, input in_data, input in_parity, output in_ready);
`else
  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
`endif
endinterface

// File: rtl/agilex_alm_lut_cfg.sv
// agilex_alm_lut_cfg
//   Loads the four LUT4 truth tables of one ALM from an 8-byte frame.
//   Bytes are assembled in shadow registers. All four active masks are
//   then updated in a single COMMIT cycle, so the ALM never sees a
//   partially written configuration.
//
//   Build option: ALM_CFG_PARITY_EN
//     defined   - in_parity is checked on each transferred byte. A frame
//                 with any bad byte is rejected at its COMMIT slot: err
//                 pulses, and the masks and cfg_valid are left unchanged.
//     undefined - no parity check; err stays 0.
//
//   Ports
//     clk         sole clock, rising edge
//     rst_n       synchronous active-low reset
//     in_if       byte stream (valid/ready/data[/parity]), slave side
//     abort       drops the frame in progress (honoured only in LOAD)
//     lut4_N_mem  active 16-bit masks driven to the ALM
//     cfg_valid   sticky; set by the first committed frame
//     busy        registered; high in LOAD and COMMIT
//     done        one-cycle pulse when a frame commits
//     err         one-cycle pulse when a frame is rejected
//
//   state  | meaning
//   IDLE   | waiting for the first byte of a frame, counter at 0
//   LOAD   | collecting bytes 1..7 into shadow
//   COMMIT | one cycle: copy shadow to the active masks (or reject the frame)

module agilex_alm_lut_cfg #(
  parameter int FRAME_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  agilex_alm_lut_cfg_if.slave  in_if,
  input  logic                 abort,
  output logic [15:0]          lut4_0_mem,
  output logic [15:0]          lut4_1_mem,
  output logic [15:0]          lut4_2_mem,
  output logic [15:0]          lut4_3_mem,
  output logic                 cfg_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Frame layout is hard-wired to 4 masks x 2 bytes.
  if (FRAME_BYTES != 8) begin : g_frame_bytes_check
    $error("agilex_alm_lut_cfg: FRAME_BYTES must be 8");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [15:0] shadow_q [4];
  logic [15:0] mask_q   [4];
  logic        cfg_valid_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        bad_q;

  logic        in_ready_d;
  logic        xfer_d;
  logic        byte_bad_d;
  logic        last_byte_d;
  logic [1:0]  slot_d;

  // Ready drops combinationally with abort, so an abort that arrives
  // together with a byte always wins.
  assign in_ready_d     = (state_q != COMMIT) && !abort;
  assign in_if.in_ready = in_ready_d;
  assign xfer_d         = in_if.in_valid && in_ready_d;

  assign slot_d      = cnt_q[2:1];
  assign last_byte_d = (cnt_q == 3'(FRAME_BYTES - 1));

`ifdef ALM_CFG_PARITY_EN
  // Odd parity: data plus parity bit must contain an odd number of ones.
  assign byte_bad_d = ~(^{in_if.in_data, in_if.in_parity});
`else
  // No check: bad_q never sets, so err_q stays 0.
  assign byte_bad_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      cfg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bad_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= 16'h0000;
        mask_q[i]   <= 16'h0000;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      case (state_q)
        IDLE, LOAD: begin
          if ((state_q == LOAD) && abort) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
              shadow_q[i] <= 16'h0000;
            end
          end else if (xfer_d) begin
            // Low byte of each mask arrives first.
            if (cnt_q[0]) begin
              shadow_q[slot_d][15:8] <= in_if.in_data;
            end else begin
              shadow_q[slot_d][7:0]  <= in_if.in_data;
            end
            bad_q  <= bad_q | byte_bad_d;
            busy_q <= 1'b1;
            if (last_byte_d) begin
              state_q <= COMMIT;
              cnt_q   <= 3'd0;
            end else begin
              state_q <= LOAD;
              cnt_q   <= cnt_q + 3'd1;
            end
          end
        end

        COMMIT: begin
          if (!bad_q) begin
            for (int i = 0; i < 4; i++) begin
              mask_q[i] <= shadow_q[i];
            end
            cfg_valid_q <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
          cnt_q   <= 3'd0;
          busy_q  <= 1'b0;
          bad_q   <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= 3'd0;
          busy_q  <= 1'b0;
          bad_q   <= 1'b0;
        end
      endcase
    end
  end

  assign lut4_0_mem = mask_q[0];
  assign lut4_1_mem = mask_q[1];
  assign lut4_2_mem = mask_q[2];
  assign lut4_3_mem = mask_q[3];
  assign cfg_valid  = cfg_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: doc/agilex_alm_lut_cfg.md
# agilex_alm_lut_cfg

Configuration loader for the Agilex ALM model's four LUT4 truth-table inputs (`lut4_0_mem`..`lut4_3_mem`). It accepts an 8-byte configuration frame over a valid/ready byte stream and assembles it in shadow registers. On frame completion it commits all four 16-bit masks to the ALM in the same cycle, so the ALM never sees a partially written configuration. It sits between a host/config bus adapter and one ALM instance.

## Interface
Parameters:
- `FRAME_BYTES`, 8: bytes per frame. Fixed at 4 masks × 2 bytes; any other value is illegal.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  byte-stream valid.
- `in_ready`  out  1  byte-stream ready.
- `in_data`  in  8  configuration byte.
- `in_parity`  in  1  odd-parity bit for `in_data`. Present only with `ALM_CFG_PARITY_EN`.
- `abort`  in  1  discards the frame in progress.
- `lut4_0_mem`..`lut4_3_mem`  out  16 each  active masks driven to the ALM.
- `cfg_valid`  out  1  high once any frame has committed.
- `busy`  out  1  high in LOAD or COMMIT.
- `done`  out  1  one-cycle pulse on commit.
- `err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- States:
  - IDLE → LOAD on the first accepted byte.
  - LOAD → COMMIT when byte 7 is accepted.
  - COMMIT → IDLE after exactly one cycle.
  - `abort` in LOAD → IDLE.
- Handshake:
  - A byte transfers when `in_valid && in_ready` at a rising edge.
  - `in_ready = (state != COMMIT) && !abort`. This is combinational from `abort`.
  - `in_data` is ignored when no transfer occurs.
- Byte placement: 3-bit counter `k`, 0..7. Byte k goes to shadow mask k>>1, bits [8*(k&1)+7 : 8*(k&1)] (low byte first). The counter clears in IDLE and on abort.
- COMMIT:
  - All four active masks load from shadow simultaneously.
  - `done` = 1 and `cfg_valid` is set (sticky until reset).
- Abort:
  - Shadow contents are discarded and the counter clears.
  - Active masks, `cfg_valid` and the COMMIT cycle are unaffected; `abort` in COMMIT or IDLE is ignored.
  - `abort` with `in_valid` in the same cycle: abort wins and no byte transfers.
- Back-to-back frames: the first byte of the next frame may transfer in the cycle after COMMIT, which is IDLE with `in_ready` = 1.

## Timing
- Reset values (after a clocked `rst_n` = 0): state IDLE, counter 0, all masks 16'h0000, shadow 0, `cfg_valid`/`busy`/`done`/`err` = 0, `in_ready` = 1 unless `abort` is high.
- Reset mid-frame: the frame is lost and active masks return to 0.
- Latency: the byte-7 transfer edge enters COMMIT. Masks and `done` become visible one edge later, i.e. 2 cycles after the byte-7 handshake cycle.
- Throughput: an uninterrupted frame takes 9 cycles (8 transfer cycles + 1 COMMIT cycle).
- `busy` is registered: high from the cycle after the first transfer through COMMIT.
- `in_valid` may drop mid-frame (bubbles). The counter holds with no timeout.

## Configuration
- Macro `ALM_CFG_PARITY_EN`.
- Defined:
  - The `in_parity` port exists.
  - Each transferred byte is checked: `^{in_data,in_parity}` must equal 1.
  - A failing byte still transfers and the counter advances, but it sets a sticky `bad` flag.
  - At byte 7 with `bad` set, the block takes the COMMIT slot without loading: masks and `cfg_valid` unchanged, `done` = 0, `err` = 1.
  - `bad` clears on IDLE entry, abort and reset.
- Undefined: no `in_parity` port, no check, `err` tied 0.

## Test plan
- Reset then frame 01 23 45 67 89 AB CD EF, continuous valid → `lut4_0_mem`=2301, `lut4_1_mem`=6745, `lut4_2_mem`=AB89, `lut4_3_mem`=EFCD; `done` pulses once; `cfg_valid`=1; masks stay 0 until the commit edge.
- Same frame with `in_valid` bubbles of 0–3 cycles between bytes → identical masks; `busy` stays high throughout; `in_ready` low only in COMMIT.
- Commit frame A (all bytes 0xFF), send 4 bytes of frame B (0x00), assert `abort` together with `in_valid` → 5th byte not accepted; masks remain FFFF; next full frame of 0x5A → all masks 5A5A.
- Two frames back-to-back (valid held high) → second frame's first byte accepted the cycle after COMMIT; two `done` pulses 9 cycles apart.
- `rst_n` = 0 after 5 bytes of a frame, following a committed 0xFF frame → all masks 0, `cfg_valid` 0; a following full frame commits normally.
- With `ALM_CFG_PARITY_EN`, a frame with a bad parity bit on byte 3 → no `done`, `err` pulse at the COMMIT slot, masks unchanged; the next correct frame commits.
